rc_input_supervisor: RTL and testbench
======================================

Name: rc_input_supervisor

Overview:
- Sequences and qualifies the 6-channel RC pulse capture datapath.
- Detects RC frame boundaries on channel 1 and validates the captured widths and period once per frame.
- Publishes a coherent per-frame channel snapshot and runs the acquire / valid / failsafe state machine.
- Sits between the RC pulse capture block and the flight-command mux; the mux uses rc_valid / failsafe to choose RC or autopilot commands.

Parameters:
- WORDSIZE, 15, width of each pulse width and of the period word (1 LSB = 1 us).
- PW_MIN, 800, minimum legal channel pulse width in us, inclusive.
- PW_MAX, 2200, maximum legal channel pulse width in us, inclusive.
- PERIOD_MIN, 5000, minimum legal frame period in us, inclusive.
- PERIOD_MAX, 30000, maximum legal frame period in us, inclusive.
- ACQ_FRAMES, 4, consecutive good frames required to declare the link valid.
- BAD_LIMIT, 3, consecutive bad frames in VALID that force FAILSAFE.
- LOSS_TICKS, 100000, pwm_clk ticks without a frame edge that force FAILSAFE (20-bit watchdog).

Ports:
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pwm_clk  in  1  1 MHz enable, high for one clk cycle per us.
- rc_en_in  in  1  remote control enable; low forces IDLE.
- pwm_ch1_in  in  1  raw channel-1 PWM line, the same pin that feeds the capture block.
- pulse_width_bus  in  6*WORDSIZE  captured widths, ch1 in bits [WORDSIZE-1:0], ch6 in the top bits.
- pulse_period  in  WORDSIZE  captured frame period.
- ch_snapshot  out  6*WORDSIZE  last accepted frame, same packing as pulse_width_bus.
- rc_valid  out  1  link qualified, commands usable.
- failsafe  out  1  link not usable.
- frame_cnt  out  8  count of accepted frames, wraps 255 -> 0.
- sup_state  out  3  current state code: IDLE=0, ACQUIRE=1, VALID=2, FAILSAFE=3.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All logic except the asynchronous reset advances only in clk cycles where pwm_clk=1 ("tick").
- Reset values: state=IDLE, rc_valid=0, failsafe=1, ch_snapshot=0, frame_cnt=0, internal counters=0, sync stages=0.
- Edge detection: pwm_ch1_in passes through a 3-stage tick-sampled pipeline s1 -> s2 -> s3. frame_edge = s2 & ~s3 on a tick, which matches the capture block's rising-edge point.
- Evaluation point: the evaluation tick is 2 ticks after frame_edge, giving capture outputs time to settle. frame_good is true only when all 6 widths lie in [PW_MIN, PW_MAX] and pulse_period lies in [PERIOD_MIN, PERIOD_MAX]. All compares are unsigned, WORDSIZE bits.
- A new frame_edge during a pending evaluation restarts the 2-tick delay; only one evaluation is performed.
- Watchdog: increments each tick and clears on frame_edge. It saturates at LOSS_TICKS. The timeout event fires once, on the tick it reaches LOSS_TICKS. A frame_edge on that same tick wins: the counter clears and no timeout fires.
- rc_en_in=0 in any state: IDLE on the next clk, not gated by tick. good_cnt, bad_cnt and the watchdog clear; ch_snapshot and frame_cnt hold.
- IDLE: rc_en_in=1 -> ACQUIRE with good_cnt=0.
- ACQUIRE:
  - good frame: good_cnt++.
  - bad frame: good_cnt=0.
  - when good_cnt reaches ACQ_FRAMES: go to VALID, latch ch_snapshot from that frame, frame_cnt++.
  - timeout: good_cnt=0, stay in ACQUIRE.
- VALID:
  - good frame: latch ch_snapshot, frame_cnt++, bad_cnt=0.
  - bad frame: bad_cnt++, snapshot held; when bad_cnt reaches BAD_LIMIT -> FAILSAFE.
  - timeout -> FAILSAFE.
- FAILSAFE: snapshot held. A good frame -> ACQUIRE with good_cnt=1; a bad frame or timeout stays in FAILSAFE.
- Outputs: rc_valid=1 only in VALID. failsafe is the complement of rc_valid. Both are registered and change the clk cycle after the state change.
- ch_snapshot updates all six channels atomically in one clk; there is never a mixed-frame snapshot.

Test Plan:
- Reset, then rc_en_in=1 with 4 frames (period 20000, all widths 1500): rc_valid rises after the 4th evaluation, ch_snapshot = 6x1500, frame_cnt=1, sup_state=2.
- In VALID, feed one frame with ch4=2300 then good frames: bad_cnt=1, snapshot keeps 1500, rc_valid stays 1. Three consecutive bad frames -> FAILSAFE, failsafe=1.
- In VALID, stop ch1 edges: failsafe=1 exactly 100000 ticks after the last frame_edge. One good frame -> ACQUIRE; 3 more good frames -> VALID.
- Boundaries: widths 800 and 2200 with period 5000 accepted; width 799 or period 30001 rejected.
- Drop rc_en_in mid-frame in VALID: sup_state=0 on the next clk, rc_valid=0, snapshot retained. Re-enable requires 4 good frames.
- Run 256 good frames: frame_cnt wraps to 0. Assert rst_n low mid-evaluation: all outputs return to reset values immediately.

Source files
------------

// File: rtl/rc_input_supervisor.sv
// ---------------------------------------------------------------------------
// rc_input_supervisor
//
// Qualifies the 6-channel RC pulse capture datapath. Rising edges of the raw
// channel-1 line mark frame boundaries; two ticks after each boundary the
// captured widths and period are range-checked. Good frames build up link
// confidence (ACQUIRE -> VALID) and publish an atomic channel snapshot; bad
// frames or a silent line drop the link into FAILSAFE.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   pwm_clk         1 MHz enable, one clk wide per microsecond ("tick")
//   rc_en_in        link enable; low forces IDLE on the next clk
//   pwm_ch1_in      raw channel-1 PWM line (frame boundary source)
//   pulse_width_bus captured widths, ch1 in the low WORDSIZE bits
//   pulse_period    captured frame period
//   ch_snapshot     last accepted frame, same packing as pulse_width_bus
//   rc_valid        link qualified, commands usable
//   failsafe        link not usable (complement of rc_valid)
//   frame_cnt       accepted-frame counter, wraps 255 -> 0
//   sup_state       IDLE=0, ACQUIRE=1, VALID=2, FAILSAFE=3
// ---------------------------------------------------------------------------
module rc_input_supervisor #(
  parameter int unsigned WORDSIZE   = 15,
  parameter int unsigned PW_MIN     = 800,
  parameter int unsigned PW_MAX     = 2200,
  parameter int unsigned PERIOD_MIN = 5000,
  parameter int unsigned PERIOD_MAX = 30000,
  parameter int unsigned ACQ_FRAMES = 4,
  parameter int unsigned BAD_LIMIT  = 3,
  parameter int unsigned LOSS_TICKS = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_clk,
  input  logic                  rc_en_in,
  input  logic                  pwm_ch1_in,
  input  logic [6*WORDSIZE-1:0] pulse_width_bus,
  input  logic [WORDSIZE-1:0]   pulse_period,
  output logic [6*WORDSIZE-1:0] ch_snapshot,
  output logic                  rc_valid,
  output logic                  failsafe,
  output logic [7:0]            frame_cnt,
  output logic [2:0]            sup_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_VALID    = 3'd2,
    ST_FAILSAFE = 3'd3
  } state_t;

  localparam logic [WORDSIZE-1:0] L_PW_MIN  = WORDSIZE'(PW_MIN);
  localparam logic [WORDSIZE-1:0] L_PW_MAX  = WORDSIZE'(PW_MAX);
  localparam logic [WORDSIZE-1:0] L_PER_MIN = WORDSIZE'(PERIOD_MIN);
  localparam logic [WORDSIZE-1:0] L_PER_MAX = WORDSIZE'(PERIOD_MAX);
  // Frame counters are 3 bits wide, so ACQ_FRAMES and BAD_LIMIT must stay below 8.
  localparam logic [2:0]          L_ACQ     = 3'(ACQ_FRAMES);
  localparam logic [2:0]          L_BAD     = 3'(BAD_LIMIT);
  localparam logic [19:0]         L_LOSS    = 20'(LOSS_TICKS);

  // Unsigned inclusive range check.
  function automatic logic in_range(input logic [WORDSIZE-1:0] v,
                                    input logic [WORDSIZE-1:0] lo,
                                    input logic [WORDSIZE-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_s1, r_s2, r_s3;
  logic [1:0]            r_eval_dly;
  logic [19:0]           r_wd;
  logic [2:0]            r_good_cnt, w_good_nxt;
  logic [2:0]            r_bad_cnt, w_bad_nxt;
  logic [6*WORDSIZE-1:0] r_snapshot;
  logic [7:0]            r_frame_cnt;
  logic                  r_rc_valid, r_failsafe;
  logic                  w_frame_edge, w_eval, w_timeout, w_frame_good, w_latch;

  // The s2/s3 pair matches the capture block's rising-edge sampling point.
  assign w_frame_edge = pwm_clk & r_s2 & ~r_s3;
  // A fresh edge on the evaluation tick restarts the delay instead of evaluating.
  assign w_eval       = pwm_clk & ~w_frame_edge & (r_eval_dly == 2'd1);
  // Fires only on the tick the watchdog steps onto LOSS_TICKS; an edge there wins.
  assign w_timeout    = rc_en_in & pwm_clk & ~w_frame_edge & (r_wd == (L_LOSS - 20'd1));

  // Range check of all six captured widths and the frame period.
  always_comb begin
    w_frame_good = in_range(pulse_period, L_PER_MIN, L_PER_MAX);
    for (int i = 0; i < 6; i++) begin
      w_frame_good = w_frame_good &
                     in_range(pulse_width_bus[i*WORDSIZE +: WORDSIZE], L_PW_MIN, L_PW_MAX);
    end
  end

  // Tick-sampled synchroniser and edge history for the channel-1 line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (pwm_clk) begin
      r_s1 <= pwm_ch1_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Two-tick settle delay between a frame edge and its evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_dly <= 2'd0;
    end else if (pwm_clk) begin
      if (w_frame_edge) begin
        r_eval_dly <= 2'd2;
      end else if (r_eval_dly != 2'd0) begin
        r_eval_dly <= r_eval_dly - 2'd1;
      end
    end
  end

  // Loss-of-signal watchdog: saturating tick counter cleared by frame edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= 20'd0;
    end else if (!rc_en_in) begin
      r_wd <= 20'd0;
    end else if (pwm_clk) begin
      if (w_frame_edge) begin
        r_wd <= 20'd0;
      end else if (r_wd < L_LOSS) begin
        r_wd <= r_wd + 20'd1;
      end
    end
  end

  // Supervisor next-state, frame counters and snapshot-latch decision.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_latch     = 1'b0;
    if (!rc_en_in) begin
      // Disable is immediate, independent of the tick enable.
      w_state_nxt = ST_IDLE;
      w_good_nxt  = 3'd0;
      w_bad_nxt   = 3'd0;
    end else if (pwm_clk) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = 3'd0;
          w_bad_nxt   = 3'd0;
        end
        ST_ACQUIRE: begin
          if (w_timeout) begin
            w_good_nxt = 3'd0;
          end else if (w_eval) begin
            if (!w_frame_good) begin
              w_good_nxt = 3'd0;
            end else if ((r_good_cnt + 3'd1) >= L_ACQ) begin
              w_state_nxt = ST_VALID;
              w_latch     = 1'b1;
              w_good_nxt  = 3'd0;
              w_bad_nxt   = 3'd0;
            end else begin
              w_good_nxt = r_good_cnt + 3'd1;
            end
          end else begin
            w_good_nxt = r_good_cnt;
          end
        end
        ST_VALID: begin
          if (w_timeout) begin
            w_state_nxt = ST_FAILSAFE;
            w_bad_nxt   = 3'd0;
          end else if (w_eval) begin
            if (w_frame_good) begin
              w_latch   = 1'b1;
              w_bad_nxt = 3'd0;
            end else if ((r_bad_cnt + 3'd1) >= L_BAD) begin
              w_state_nxt = ST_FAILSAFE;
              w_bad_nxt   = 3'd0;
            end else begin
              w_bad_nxt = r_bad_cnt + 3'd1;
            end
          end else begin
            w_bad_nxt = r_bad_cnt;
          end
        end
        ST_FAILSAFE: begin
          // The recovering frame already counts towards re-acquisition.
          if (w_eval && w_frame_good && !w_timeout) begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = 3'd1;
          end else begin
            w_state_nxt = ST_FAILSAFE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_good_nxt  = 3'd0;
          w_bad_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Supervisor state and frame-quality counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= 3'd0;
      r_bad_cnt  <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
    end
  end

  // All six channels latch in the same clk, so the snapshot is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snapshot  <= '0;
      r_frame_cnt <= 8'd0;
    end else if (w_latch) begin
      r_snapshot  <= pulse_width_bus;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Link status flags, one clk behind the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc_valid <= 1'b0;
      r_failsafe <= 1'b1;
    end else begin
      r_rc_valid <= (r_state == ST_VALID);
      r_failsafe <= (r_state != ST_VALID);
    end
  end

  assign ch_snapshot = r_snapshot;
  assign frame_cnt   = r_frame_cnt;
  assign rc_valid    = r_rc_valid;
  assign failsafe    = r_failsafe;
  assign sup_state   = r_state;

endmodule

// File: tb/tb_rc_input_supervisor.sv
module tb_rc_input_supervisor;

  localparam int W    = 15;
  localparam int LOSS = 300;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACQ  = 3'd1;
  localparam logic [2:0] S_VAL  = 3'd2;
  localparam logic [2:0] S_FS   = 3'd3;

  logic           clk;
  logic           rst_n;
  logic           pwm_clk;
  logic           rc_en_in;
  logic           pwm_ch1_in;
  logic [6*W-1:0] pulse_width_bus;
  logic [W-1:0]   pulse_period;
  logic [6*W-1:0] ch_snapshot;
  logic           rc_valid;
  logic           failsafe;
  logic [7:0]     frame_cnt;
  logic [2:0]     sup_state;

  typedef struct {
    string          tag;
    logic [2:0]     st;
    logic           v;
    logic           fs;
    logic [7:0]     fc;
    logic [6*W-1:0] snap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_div = 0;

  // Reference model of the supervisor, advanced per evaluated frame.
  logic [2:0]     m_st;
  int             m_good;
  int             m_bad;
  logic [7:0]     m_fc;
  logic [6*W-1:0] m_snap;

  rc_input_supervisor #(.LOSS_TICKS(LOSS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_clk        (pwm_clk),
    .rc_en_in       (rc_en_in),
    .pwm_ch1_in     (pwm_ch1_in),
    .pulse_width_bus(pulse_width_bus),
    .pulse_period   (pulse_period),
    .ch_snapshot    (ch_snapshot),
    .rc_valid       (rc_valid),
    .failsafe       (failsafe),
    .frame_cnt      (frame_cnt),
    .sup_state      (sup_state)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // One tick every third clk.
  initial begin
    pwm_clk = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div == 2) ? 0 : tick_div + 1;
      pwm_clk  = (tick_div == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [6*W-1:0] all6(input logic [W-1:0] w);
    return {6{w}};
  endfunction

  function automatic logic [6*W-1:0] set_ch(input logic [6*W-1:0] b, input int ch,
                                            input logic [W-1:0] w);
    logic [6*W-1:0] r;
    r = b;
    r[(ch-1)*W +: W] = w;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [6*W-1:0] obs, input logic [6*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.st   = m_st;
    e.v    = (m_st == S_VAL);
    e.fs   = (m_st != S_VAL);
    e.fc   = m_fc;
    e.snap = m_snap;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_state"}, sup_state, e.st);
      chk({e.tag, "_valid"}, rc_valid, e.v);
      chk({e.tag, "_failsafe"}, failsafe, e.fs);
      chk({e.tag, "_fcnt"}, frame_cnt, e.fc);
      chk({e.tag, "_snap"}, ch_snapshot, e.snap);
    end
  endtask

  task automatic model_eval(input bit good, input logic [6*W-1:0] bus);
    case (m_st)
      S_ACQ: begin
        if (good) begin
          m_good++;
          if (m_good == 4) begin
            m_st = S_VAL; m_snap = bus; m_fc = m_fc + 8'd1; m_good = 0;
          end
        end else begin
          m_good = 0;
        end
      end
      S_VAL: begin
        if (good) begin
          m_snap = bus; m_fc = m_fc + 8'd1; m_bad = 0;
        end else begin
          m_bad++;
          if (m_bad == 3) begin
            m_st = S_FS; m_bad = 0;
          end
        end
      end
      S_FS: begin
        if (good) begin
          m_st = S_ACQ; m_good = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_timeout();
    if (m_st == S_ACQ) m_good = 0;
    else if (m_st == S_VAL) begin m_st = S_FS; m_bad = 0; end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_good = 0; m_bad = 0; m_fc = 8'd0; m_snap = '0;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!pwm_clk) @(posedge clk);
    end
    #1;
  endtask

  // One RC frame: ch1 high 3 ticks, low 5 ticks; the evaluation falls on tick 5.
  task automatic frame(input logic [6*W-1:0] bus, input logic [W-1:0] per,
                       input bit good, input string tag);
    @(negedge clk);
    pulse_width_bus = bus;
    pulse_period    = per;
    pwm_ch1_in      = 1'b1;
    model_eval(good, bus);
    push_exp(tag);
    wait_ticks(3);
    @(negedge clk);
    pwm_ch1_in = 1'b0;
    wait_ticks(5);
    pop_check();
  endtask

  logic [6*W-1:0] bnd;
  int             n_wrap;

  initial begin
    rst_n = 1'b0; rc_en_in = 1'b0; pwm_ch1_in = 1'b0;
    pulse_width_bus = '0; pulse_period = '0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    push_exp("reset"); pop_check();

    @(negedge clk); rst_n = 1'b1;
    wait_ticks(2);
    push_exp("idle_disabled"); pop_check();

    // Enable and acquire with four nominal frames.
    @(negedge clk); rc_en_in = 1'b1;
    wait_ticks(2);
    m_st = S_ACQ; m_good = 0; m_bad = 0;
    push_exp("enable"); pop_check();
    for (int i = 0; i < 4; i++) frame(all6(15'd1500), 15'd20000, 1'b1, "acq");
    chk("acq_state_const", sup_state, S_VAL);
    chk("acq_fcnt_const", frame_cnt, 8'd1);
    chk("acq_snap_const", ch_snapshot, all6(15'd1500));

    // Bad frames in VALID; an intervening good frame clears the bad count.
    frame(set_ch(all6(15'd1500), 4, 15'd2300), 15'd20000, 1'b0, "bad_ch4");
    frame(all6(15'd1500), 15'd20000, 1'b1, "good_after_bad");
    frame(set_ch(all6(15'd1500), 4, 15'd2300), 15'd20000, 1'b0, "bad_a");
    frame(set_ch(all6(15'd1500), 2, 15'd100), 15'd20000, 1'b0, "bad_b");
    chk("two_bad_still_valid", rc_valid, 1'b1);
    frame(set_ch(all6(15'd1500), 4, 15'd2300), 15'd20000, 1'b0, "bad_c");
    chk("three_bad_failsafe", failsafe, 1'b1);

    // Boundary widths/period accepted, re-acquire from FAILSAFE.
    bnd = all6(15'd800);
    bnd = set_ch(bnd, 2, 15'd2200);
    bnd = set_ch(bnd, 4, 15'd2200);
    bnd = set_ch(bnd, 6, 15'd2200);
    for (int i = 0; i < 4; i++) frame(bnd, 15'd5000, 1'b1, "bnd_acq");
    chk("bnd_snap_const", ch_snapshot, bnd);
    frame(set_ch(bnd, 1, 15'd799), 15'd5000, 1'b0, "w799");
    frame(all6(15'd1500), 15'd30000, 1'b1, "per30000");
    frame(all6(15'd1500), 15'd30001, 1'b0, "per30001");
    frame(bnd, 15'd5000, 1'b1, "bnd_again");
    frame(set_ch(bnd, 6, 15'd2201), 15'd5000, 1'b0, "w2201");
    frame(all6(15'd1500), 15'd4999, 1'b0, "per4999");
    frame(all6(15'd1500), 15'd20000, 1'b1, "good_mid");

    // Loss of frames: failsafe exactly LOSS ticks after the last frame edge.
    frame(all6(15'd1500), 15'd20000, 1'b1, "wd_last");
    wait_ticks(LOSS - 6);
    push_exp("wd_before"); pop_check();
    wait_ticks(1);
    model_timeout();
    chk("wd_state", sup_state, S_FS);
    chk("wd_failsafe_lag", failsafe, 1'b0);
    @(posedge clk); #1;
    push_exp("wd_after"); pop_check();
    frame(all6(15'd1400), 15'd20000, 1'b1, "wd_recover");
    chk("wd_recover_acq", sup_state, S_ACQ);
    for (int i = 0; i < 3; i++) frame(all6(15'd1450), 15'd20000, 1'b1, "wd_reacq");
    chk("wd_reacq_valid", sup_state, S_VAL);

    // Disable mid-frame in VALID.
    @(negedge clk);
    pulse_width_bus = all6(15'd1700); pulse_period = 15'd20000; pwm_ch1_in = 1'b1;
    wait_ticks(2);
    @(negedge clk); rc_en_in = 1'b0;
    m_st = S_IDLE; m_good = 0; m_bad = 0;
    @(posedge clk); #1;
    chk("dis_state_next_clk", sup_state, S_IDLE);
    chk("dis_valid_lag", rc_valid, 1'b1);
    @(posedge clk); #1;
    push_exp("disabled"); pop_check();
    wait_ticks(1);
    @(negedge clk); pwm_ch1_in = 1'b0;
    wait_ticks(8);
    push_exp("disabled_hold"); pop_check();

    // Re-enable, then a timeout in ACQUIRE discards partial progress.
    @(negedge clk); rc_en_in = 1'b1;
    wait_ticks(2);
    m_st = S_ACQ; m_good = 0; m_bad = 0;
    push_exp("reenable"); pop_check();
    for (int i = 0; i < 2; i++) frame(all6(15'd1550), 15'd20000, 1'b1, "pre_to");
    wait_ticks(LOSS);
    model_timeout();
    push_exp("acq_timeout"); pop_check();
    for (int i = 0; i < 3; i++) frame(all6(15'd1600), 15'd20000, 1'b1, "post_to");
    chk("post_to_acq", sup_state, S_ACQ);
    frame(all6(15'd1600), 15'd20000, 1'b1, "post_to_4th");
    chk("post_to_valid", sup_state, S_VAL);

    // Frame counter wrap.
    n_wrap = 256 - int'(m_fc);
    for (int i = 0; i < n_wrap; i++) frame(all6(15'(1000 + i * 3)), 15'd20000, 1'b1, "wrap");
    chk("wrap_fcnt_zero", frame_cnt, 8'd0);

    // Asynchronous reset between frame edge and evaluation.
    @(negedge clk);
    pulse_width_bus = all6(15'd1234); pwm_ch1_in = 1'b1;
    wait_ticks(4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_exp("rst_mid_eval"); pop_check();
    pwm_ch1_in = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
